alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised sequential integer ALU for the execute stage. It keeps the eight single-cycle operations of the current 64-bit ALU and adds iterative multiply, multiply-high, divide and remainder. Operands are captured over a valid/ready handshake and results are registered and presented over a second handshake. A synchronous flush lets the pipeline kill an in-flight operation.

## Interface
- WIDTH, 64: operand/result width; must be ≥8 and a power of two.
- SHW, $clog2(WIDTH): shift-amount width (derived; do not override).
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill; returns the block to IDLE.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept (high only in IDLE).
- funct  input  4  operation: 0 SUM, 1 SHIFT_LEFT, 2 SUB, 3 LOAD, 4 XOR, 5 SHIFT_RIGHT, 6 NOT, 7 AND, 8 MUL, 9 MULH, 10 DIV, 11 REM, 12–15 reserved.
- a, b  input  WIDTH each  signed operands.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- overflow, negative, zero, equal, greater, less  output  1 each  status flags, registered with result.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE → DONE: on accept of funct 0–7 or 12–15.
  - IDLE → CALC: on accept of funct 8–11.
  - CALC → DONE: after WIDTH iterations.
  - DONE → IDLE: when out_ready is high.
- Accept = in_valid & in_ready. a, b and funct are latched on accept; the inputs are don't-care otherwise.
- Single-cycle ops:
  - SUM = a+b; SUB = a−b.
  - Shifts use only b[SHW-1:0]. SHIFT_RIGHT is logical.
  - LOAD = a; NOT = ~a; AND, XOR bitwise.
  - Reserved codes give result 0.
- MUL: low WIDTH bits of a×b.
- MULH: high WIDTH bits of the signed 2·WIDTH product.
  - Computed radix-2 on magnitudes, with sign correction at the end.
  - Uses one add/shift step per CALC cycle.
- DIV/REM: signed division, quotient truncated toward zero; the remainder takes the sign of a.
  - Restoring algorithm on magnitudes, one bit per CALC cycle.
- DIV/REM special cases, resolved at accept but still taking the full CALC latency:
  - b=0: DIV gives all ones; REM gives a.
  - a = most-negative and b = −1: DIV gives a; REM gives 0.
- Flags, captured with the result:
  - overflow: signed overflow for SUM/SUB only; 0 for all other ops.
  - negative = result[WIDTH-1]; zero = (result==0).
  - equal, greater, less: signed compares of the latched a and b.
- flush:
  - Any state → IDLE at the next edge; out_valid drops and any partial result is discarded.
  - An accept in the same cycle as flush is ignored.

## Timing
- Reset (async assert, sync-released deassert) puts the FSM in IDLE.
  - Reset values: in_ready=1, out_valid=0, result=0, all flags=0, iteration counter=0.
- Single-cycle op accepted at edge N: out_valid=1 from after edge N+1.
- MUL/MULH/DIV/REM accepted at edge N: CALC spans N+1..N+WIDTH; out_valid=1 after edge N+WIDTH+1.
- out_valid, result and flags hold stable while out_valid & !out_ready (backpressure); no timeout.
- in_ready=0 from accept until the cycle after the result handshake.
  - Back-to-back single-cycle ops therefore sustain 1 result per 2 cycles.
- rst_n asserted mid-CALC: immediate IDLE with reset values; no result is produced.
- The iteration counter is SHW+1 bits wide and wraps to 0 on leaving CALC.

## Test plan
- WIDTH=64, SUM a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> 1 cycle later: result=0x8000_0000_0000_0000, overflow=1, negative=1, greater=1.
- SHIFT_LEFT a=1, b=0x41 -> result=2 (only b[5:0]=1 used), zero=0.
- MULH a=−2, b=3 -> out_valid after 65 cycles, result=0xFFFF_FFFF_FFFF_FFFF. MUL with the same operands -> 0xFFFF_FFFF_FFFF_FFFA.
- DIV a=−7, b=2 -> result=−3; REM -> −1. DIV by 0 -> all ones; REM by 0 -> a. DIV 0x8000…0 by −1 -> 0x8000…0, and REM -> 0.
- Handshake: hold out_ready=0 for 10 cycles after out_valid -> result and flags unchanged and in_ready=0. Raise out_ready -> in_ready=1 next cycle.
- Pulse flush at CALC cycle 20 of a DIV -> IDLE next cycle with no out_valid. Repeat with rst_n pulsed low mid-CALC -> all outputs at reset values immediately. Rerun the arithmetic cases at WIDTH=32 and confirm out_valid after 33 cycles.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential signed ALU: 8 single-cycle ops plus iterative MUL/MULH/DIV/REM.
// Latency: single-cycle ops 1 cycle after accept; iterative ops WIDTH+1 cycles after accept.
// Backpressure: result and flags held while out_valid & !out_ready; in_ready only in IDLE.
module alu_seq #(
    parameter int WIDTH = 64,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             negative,
    output logic             zero,
    output logic             equal,
    output logic             greater,
    output logic             less
);

    localparam int CW = SHW + 1;
    localparam int M  = WIDTH - 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [3:0]       op_q;
    logic             neg_res_q, neg_rem_q, spec_en_q;
    logic             cmp_eq_q, cmp_gt_q, cmp_lt_q;
    logic [WIDTH-1:0] spec_q, addend_q, hi_q, lo_q;

    logic             acc, is_iter, last;
    logic [WIDTH-1:0] sum_v, sub_v, sc_res;
    logic             sc_ovf;
    logic [WIDTH-1:0] mag_a, mag_b, spec_val;
    logic             b_zero, div_ovf, is_divrem;
    logic [WIDTH:0]   madd, shifted, trial;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0] quo_s, rem_s, fin_res;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign acc       = in_valid & in_ready & ~flush;
    assign is_iter   = (funct[3:2] == 2'b10);
    assign is_divrem = (funct[3:1] == 3'b101);
    assign last      = (state_q == CALC) && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc) state_d = is_iter ? CALC : DONE;
            CALC:    if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        sum_v  = a + b;
        sub_v  = a - b;
        sc_res = '0;
        sc_ovf = 1'b0;
        case (funct)
            4'd0: begin
                sc_res = sum_v;
                sc_ovf = (a[M] == b[M]) && (sum_v[M] != a[M]);
            end
            4'd1: sc_res = a << b[SHW-1:0];
            4'd2: begin
                sc_res = sub_v;
                sc_ovf = (a[M] != b[M]) && (sub_v[M] != a[M]);
            end
            4'd3:    sc_res = a;
            4'd4:    sc_res = a ^ b;
            4'd5:    sc_res = a >> b[SHW-1:0];
            4'd6:    sc_res = ~a;
            4'd7:    sc_res = a & b;
            default: sc_res = '0;
        endcase
    end

    // Most-negative maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
    always_comb begin
        mag_a    = a[M] ? -a : a;
        mag_b    = b[M] ? -b : b;
        b_zero   = (b == '0);
        div_ovf  = (a == MIN_NEG) && (b == '1);
        if (funct[0]) begin
            spec_val = b_zero ? a : '0;
        end else begin
            spec_val = b_zero ? '1 : a;
        end
    end

    // One shift-add (multiply) or one restoring subtract (divide) per CALC cycle.
    always_comb begin
        madd    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, addend_q} : {(WIDTH+1){1'b0}});
        shifted = {hi_q, lo_q[M]};
        trial   = shifted - {1'b0, addend_q};
        if (!op_q[1]) begin
            hi_d = madd[WIDTH:1];
            lo_d = {madd[0], lo_q[M:1]};
        end else if (!trial[WIDTH]) begin
            hi_d = trial[M:0];
            lo_d = {lo_q[M-1:0], 1'b1};
        end else begin
            hi_d = shifted[M:0];
            lo_d = {lo_q[M-1:0], 1'b0};
        end
    end

    always_comb begin
        prod   = {hi_d, lo_d};
        prod_s = neg_res_q ? -prod : prod;
        quo_s  = neg_res_q ? -lo_d : lo_d;
        rem_s  = neg_rem_q ? -hi_d : hi_d;
        case (op_q[1:0])
            2'b00:   fin_res = prod_s[M:0];
            2'b01:   fin_res = prod_s[2*WIDTH-1:WIDTH];
            2'b10:   fin_res = quo_s;
            default: fin_res = rem_s;
        endcase
        if (spec_en_q) begin
            fin_res = spec_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            spec_en_q <= 1'b0;
            spec_q    <= '0;
            addend_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cmp_eq_q  <= 1'b0;
            cmp_gt_q  <= 1'b0;
            cmp_lt_q  <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            equal     <= 1'b0;
            greater   <= 1'b0;
            less      <= 1'b0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (acc) begin
            cnt_q     <= '0;
            op_q      <= funct;
            cmp_eq_q  <= (a == b);
            cmp_gt_q  <= ($signed(a) > $signed(b));
            cmp_lt_q  <= ($signed(a) < $signed(b));
            neg_res_q <= a[M] ^ b[M];
            neg_rem_q <= a[M];
            spec_en_q <= is_divrem & (b_zero | div_ovf);
            spec_q    <= spec_val;
            hi_q      <= '0;
            if (funct[1]) begin
                lo_q     <= mag_a;
                addend_q <= mag_b;
            end else begin
                lo_q     <= mag_b;
                addend_q <= mag_a;
            end
            if (!is_iter) begin
                result   <= sc_res;
                overflow <= sc_ovf;
                negative <= sc_res[M];
                zero     <= (sc_res == '0);
                equal    <= (a == b);
                greater  <= ($signed(a) > $signed(b));
                less     <= ($signed(a) < $signed(b));
            end
        end else if (state_q == CALC) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            if (last) begin
                cnt_q    <= '0;
                result   <= fin_res;
                overflow <= 1'b0;
                negative <= fin_res[M];
                zero     <= (fin_res == '0);
                equal    <= cmp_eq_q;
                greater  <= cmp_gt_q;
                less     <= cmp_lt_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: vector table + random ops through a scoreboard queue, plus
// backpressure, flush, mid-CALC reset and a WIDTH=32 latency/arith check.
module tb_alu_seq;

    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  funct = '0;
    logic [63:0] a = '0, b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        overflow, negative, zero, equal, greater, less;

    logic        flush32 = 1'b0;
    logic        in_valid32 = 1'b0;
    logic        in_ready32;
    logic [3:0]  funct32 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        out_valid32;
    logic        out_ready32 = 1'b1;
    logic [31:0] result32;
    logic        ovf32, neg32, zero32, eq32, gt32, lt32;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct(funct), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .negative(negative),
        .zero(zero), .equal(equal), .greater(greater), .less(less)
    );

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush32),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .funct(funct32), .a(a32), .b(b32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .result(result32), .overflow(ovf32), .negative(neg32),
        .zero(zero32), .equal(eq32), .greater(gt32), .less(lt32)
    );

    typedef struct {
        logic [3:0]  f;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic [5:0]  flg;
        int          lat;
    } exp_t;

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sbq[$];
    vec_t tbl[24];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t mk_exp(input vec_t v);
        exp_t e;
        e.res = v.res;
        e.flg = {v.ovf, v.res[63], v.res == 64'd0, v.a == v.b,
                 $signed(v.a) > $signed(v.b), $signed(v.a) < $signed(v.b)};
        e.lat = (v.f >= 4'd8 && v.f <= 4'd11) ? 65 : 1;
        return e;
    endfunction

    // Reference arithmetic built on the simulator's native signed operators.
    function automatic logic [64:0] model(input logic [3:0] f, input logic [63:0] x, input logic [63:0] y);
        logic [63:0] r;
        logic o;
        logic signed [127:0] px, py, p;
        r = '0;
        o = 1'b0;
        px = $signed(x);
        py = $signed(y);
        p = px * py;
        case (f)
            4'd0: begin r = x + y; o = (x[63] == y[63]) && (r[63] != x[63]); end
            4'd1: r = x << y[5:0];
            4'd2: begin r = x - y; o = (x[63] != y[63]) && (r[63] != x[63]); end
            4'd3: r = x;
            4'd4: r = x ^ y;
            4'd5: r = x >> y[5:0];
            4'd6: r = ~x;
            4'd7: r = x & y;
            4'd8: r = p[63:0];
            4'd9: r = p[127:64];
            4'd10: begin
                if (y == 64'd0) r = '1;
                else if (x == MINV && y == '1) r = x;
                else r = $signed(x) / $signed(y);
            end
            4'd11: begin
                if (y == 64'd0) r = x;
                else if (x == MINV && y == '1) r = '0;
                else r = $signed(x) % $signed(y);
            end
            default: r = '0;
        endcase
        return {o, r};
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        exp_t e;
        int lat;
        sbq.push_back(mk_exp(v));
        funct = v.f; a = v.a; b = v.b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sbq.pop_front();
        check($sformatf("%s valid", tag), 64'(out_valid), 64'd1);
        check($sformatf("%s latency", tag), 64'(lat), 64'(e.lat));
        check($sformatf("%s result", tag), result, e.res);
        check($sformatf("%s flags", tag),
              64'({overflow, negative, zero, equal, greater, less}), 64'(e.flg));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run32(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input string tag);
        int lat;
        int exp_lat;
        exp_lat = (f >= 4'd8 && f <= 4'd11) ? 33 : 1;
        funct32 = f; a32 = x; b32 = y; in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        lat = 1;
        while (!out_valid32 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("w32 %s latency", tag), 64'(lat), 64'(exp_lat));
        check($sformatf("w32 %s result", tag), 64'(result32), 64'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t v;
        int sv;
        int cyc;
        logic seen;

        tbl[0]  = '{4'd0,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, MINV, 1'b1};
        tbl[1]  = '{4'd1,  64'd1, 64'h41, 64'd2, 1'b0};
        tbl[2]  = '{4'd2,  MINV, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
        tbl[3]  = '{4'd3,  64'h1234, 64'd5, 64'h1234, 1'b0};
        tbl[4]  = '{4'd4,  64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0};
        tbl[5]  = '{4'd5,  MINV, 64'd63, 64'd1, 1'b0};
        tbl[6]  = '{4'd6,  64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[7]  = '{4'd7,  64'hFF00FF, 64'h0F0F0F, 64'h0F000F, 1'b0};
        tbl[8]  = '{4'd12, 64'd5, 64'd5, 64'd0, 1'b0};
        tbl[9]  = '{4'd9,  64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[10] = '{4'd8,  64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0};
        tbl[11] = '{4'd10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
        tbl[12] = '{4'd11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[13] = '{4'd10, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[14] = '{4'd11, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0};
        tbl[15] = '{4'd10, MINV, 64'hFFFF_FFFF_FFFF_FFFF, MINV, 1'b0};
        tbl[16] = '{4'd11, MINV, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0};
        tbl[17] = '{4'd9,  64'h1_0000_0001, 64'h1_0000_0001, 64'd1, 1'b0};
        tbl[18] = '{4'd8,  64'h1_0000_0001, 64'h1_0000_0001, 64'h2_0000_0001, 1'b0};
        tbl[19] = '{4'd10, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0};
        tbl[20] = '{4'd11, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0};
        tbl[21] = '{4'd0,  64'd7, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 1'b0};
        tbl[22] = '{4'd2,  64'd0, MINV, MINV, 1'b1};
        tbl[23] = '{4'd5,  64'hFFFF_FFFF_FFFF_FFFF, 64'h44, 64'h0FFF_FFFF_FFFF_FFFF, 1'b0};

        #12;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", result, 64'd0);
        check("reset flags", 64'({overflow, negative, zero, equal, greater, less}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            run_op(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            v.f = 4'($urandom_range(0, 11));
            v.a = {$urandom, $urandom};
            v.b = {$urandom, $urandom};
            if (i % 3 == 0) begin
                sv = int'($urandom_range(0, 8)) - 4;
                v.b = {{32{sv[31]}}, sv};
            end
            {v.ovf, v.res} = model(v.f, v.a, v.b);
            run_op(v, $sformatf("rnd%0d f%0d", i, v.f));
        end

        // Backpressure: result held, in_ready low until handshake.
        funct = 4'd0; a = 64'd3; b = 64'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp hold valid", 64'(out_valid), 64'd1);
            check("bp hold result", result, 64'd7);
            check("bp hold flags", 64'({overflow, negative, zero, equal, greater, less}), 64'b000001);
            check("bp in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp release valid", 64'(out_valid), 64'd0);
        check("bp release in_ready", 64'(in_ready), 64'd1);

        run32(4'd0,  32'h7FFF_FFFF, 32'd1, 32'h8000_0000, "sum");
        run32(4'd9,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, "mulh");
        run32(4'd8,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, "mul");
        run32(4'd10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div");
        run32(4'd11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem");
        run32(4'd10, 32'd9, 32'd0, 32'hFFFF_FFFF, "div0");
        run32(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "divovf");
        run32(4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "removf");

        // Flush at CALC cycle 20 of a DIV.
        funct = 4'd10; a = 64'd1000; b = 64'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush in_ready", 64'(in_ready), 64'd1);
        check("flush out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        for (cyc = 0; cyc < 80; cyc++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush no result", 64'(seen), 64'd0);

        funct = 4'd0; a = 64'd1; b = 64'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush+accept out_valid", 64'(out_valid), 64'd0);
        check("flush+accept in_ready", 64'(in_ready), 64'd1);
        run_op(tbl[11], "after flush");

        // Reset mid-CALC of a MUL; result register is nonzero beforehand.
        funct = 4'd8; a = 64'd3; b = 64'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("rst mid in_ready", 64'(in_ready), 64'd1);
        check("rst mid out_valid", 64'(out_valid), 64'd0);
        check("rst mid result", result, 64'd0);
        check("rst mid flags", 64'({overflow, negative, zero, equal, greater, less}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (cyc = 0; cyc < 80; cyc++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("rst mid no result", 64'(seen), 64'd0);
        run_op(tbl[0], "after reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
